branch_predictor_bht: RTL and testbench

//  Parametrised branch history table: 2^INDEX_BITS saturating counters indexed by PC,

---
 rtl/branch_predictor_bht.sv | 128 ++++++++++++
 tb/tb_branch_predictor_bht.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor_bht.sv
// ---------------------------------------------------------------------------
// branch_predictor_bht
//   PC-indexed branch history table of 2^INDEX_BITS saturating counters.
//   The IF stage issues lookups and receives a registered taken/not-taken
//   prediction one cycle later. The EX stage trains the table with resolved
//   outcomes. Saturating resolved-branch and mispredict counters are kept
//   for performance debug.
//
// Ports
//   clkFSM         in   1          clock, rising edge
//   reset          in   1          asynchronous active-low reset
//   lookup_valid   in   1          prediction request this cycle
//   lookup_pc      in   PC_WIDTH   PC of the fetched instruction
//   prediction     out  1          1 = predict taken (registered)
//   pred_valid     out  1          lookup_valid delayed one cycle
//   upd_valid      in   1          a conditional branch resolved this cycle
//   upd_pc         in   PC_WIDTH   PC of the resolved branch
//   upd_taken      in   1          actual outcome, 1 = taken
//   upd_predicted  in   1          prediction that was used for the branch
//   stat_clear     in   1          synchronous clear of both statistics
//   branch_count   out  STAT_BITS  resolved branches, saturating
//   mispred_count  out  STAT_BITS  mispredictions, saturating
// ---------------------------------------------------------------------------
module branch_predictor_bht #(
    parameter int unsigned PC_WIDTH   = 32,
    parameter int unsigned INDEX_BITS = 4,
    parameter int unsigned CTR_BITS   = 2,
    parameter int unsigned STAT_BITS  = 16
) (
    input  logic                 clkFSM,
    input  logic                 reset,
    input  logic                 lookup_valid,
    input  logic [PC_WIDTH-1:0]  lookup_pc,
    output logic                 prediction,
    output logic                 pred_valid,
    input  logic                 upd_valid,
    input  logic [PC_WIDTH-1:0]  upd_pc,
    input  logic                 upd_taken,
    input  logic                 upd_predicted,
    input  logic                 stat_clear,
    output logic [STAT_BITS-1:0] branch_count,
    output logic [STAT_BITS-1:0] mispred_count
);

    localparam int unsigned ENTRIES = 1 << INDEX_BITS;
    localparam int unsigned IDX_LO  = 2;
    localparam int unsigned IDX_HI  = INDEX_BITS + 1;

    localparam logic [CTR_BITS-1:0]  CTR_INIT = CTR_BITS'(1 << (CTR_BITS - 1));
    localparam logic [CTR_BITS-1:0]  CTR_MAX  = {CTR_BITS{1'b1}};
    localparam logic [CTR_BITS-1:0]  CTR_MIN  = '0;
    localparam logic [STAT_BITS-1:0] STAT_MAX = {STAT_BITS{1'b1}};

    logic [CTR_BITS-1:0]   ctr_q [ENTRIES];
    logic [INDEX_BITS-1:0] lookup_idx_c;
    logic [INDEX_BITS-1:0] upd_idx_c;
    logic [CTR_BITS-1:0]   upd_cur_c;
    logic [CTR_BITS-1:0]   upd_next_c;
    logic                  mispred_c;
    logic                  unused_pc_bits_c;

    // Word-aligned index; pc[1:0] and high PC bits alias onto the same entry.
    assign lookup_idx_c = lookup_pc[IDX_HI:IDX_LO];
    assign upd_idx_c    = upd_pc[IDX_HI:IDX_LO];
    assign mispred_c    = upd_taken ^ upd_predicted;

    // Bits outside the index field are intentionally ignored.
    assign unused_pc_bits_c = ^{lookup_pc, upd_pc};

    // Saturating increment/decrement of the entry being trained.
    always_comb begin
        upd_cur_c  = ctr_q[upd_idx_c];
        upd_next_c = upd_cur_c;
        if (upd_taken) begin
            if (upd_cur_c != CTR_MAX) begin
                upd_next_c = upd_cur_c + CTR_BITS'(1);
            end
        end else begin
            if (upd_cur_c != CTR_MIN) begin
                upd_next_c = upd_cur_c - CTR_BITS'(1);
            end
        end
    end

    // Counter table; reset returns every entry to weakly taken.
    always_ff @(posedge clkFSM or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                ctr_q[i] <= CTR_INIT;
            end
        end else if (upd_valid) begin
            ctr_q[upd_idx_c] <= upd_next_c;
        end
    end

    // Registered prediction; the table read sees the pre-update value when
    // a lookup and an update hit the same entry in the same cycle.
    always_ff @(posedge clkFSM or negedge reset) begin
        if (!reset) begin
            prediction <= 1'b1;
            pred_valid <= 1'b0;
        end else begin
            pred_valid <= lookup_valid;
            if (lookup_valid) begin
                prediction <= ctr_q[lookup_idx_c][CTR_BITS-1];
            end
        end
    end

    // Statistics; clear wins over a same-cycle increment.
    always_ff @(posedge clkFSM or negedge reset) begin
        if (!reset) begin
            branch_count  <= '0;
            mispred_count <= '0;
        end else if (stat_clear) begin
            branch_count  <= '0;
            mispred_count <= '0;
        end else if (upd_valid) begin
            if (branch_count != STAT_MAX) begin
                branch_count <= branch_count + STAT_BITS'(1);
            end
            if (mispred_c && (mispred_count != STAT_MAX)) begin
                mispred_count <= mispred_count + STAT_BITS'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor_bht.sv
// ---------------------------------------------------------------------------
// tb_branch_predictor_bht
//   Directed bench for branch_predictor_bht. A default instance (16 entries,
//   2-bit counters, 16-bit stats) and a second instance with 4-bit stats
//   share the same stimulus.
// ---------------------------------------------------------------------------
module tb_branch_predictor_bht;

    logic        clkFSM;
    logic        reset;
    logic        lookup_valid;
    logic [31:0] lookup_pc;
    logic        prediction;
    logic        pred_valid;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic        upd_predicted;
    logic        stat_clear;
    logic [15:0] branch_count;
    logic [15:0] mispred_count;

    logic        prediction_s;
    logic        pred_valid_s;
    logic [3:0]  branch_count_s;
    logic [3:0]  mispred_count_s;

    int checks = 0;
    int errors = 0;

    branch_predictor_bht #(
        .PC_WIDTH(32), .INDEX_BITS(4), .CTR_BITS(2), .STAT_BITS(16)
    ) dut (
        .clkFSM(clkFSM), .reset(reset),
        .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
        .prediction(prediction), .pred_valid(pred_valid),
        .upd_valid(upd_valid), .upd_pc(upd_pc),
        .upd_taken(upd_taken), .upd_predicted(upd_predicted),
        .stat_clear(stat_clear),
        .branch_count(branch_count), .mispred_count(mispred_count)
    );

    branch_predictor_bht #(
        .PC_WIDTH(32), .INDEX_BITS(4), .CTR_BITS(2), .STAT_BITS(4)
    ) dut_s (
        .clkFSM(clkFSM), .reset(reset),
        .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
        .prediction(prediction_s), .pred_valid(pred_valid_s),
        .upd_valid(upd_valid), .upd_pc(upd_pc),
        .upd_taken(upd_taken), .upd_predicted(upd_predicted),
        .stat_clear(stat_clear),
        .branch_count(branch_count_s), .mispred_count(mispred_count_s)
    );

    initial clkFSM = 1'b0;
    always #5 clkFSM = ~clkFSM;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clkFSM);
        #1;
    endtask

    task automatic do_update(input logic [31:0] pc, input logic taken, input logic predicted);
        upd_valid     = 1'b1;
        upd_pc        = pc;
        upd_taken     = taken;
        upd_predicted = predicted;
        tick();
        upd_valid     = 1'b0;
    endtask

    task automatic do_lookup(input logic [31:0] pc);
        lookup_valid = 1'b1;
        lookup_pc    = pc;
        tick();
        lookup_valid = 1'b0;
        lookup_pc    = 32'h0;
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        lookup_valid  = 1'b0;
        lookup_pc     = 32'h0;
        upd_valid     = 1'b0;
        upd_pc        = 32'h0;
        upd_taken     = 1'b0;
        upd_predicted = 1'b0;
        stat_clear    = 1'b0;
        #2 reset = 1'b0;
        #2;
        checks++;
        if (prediction !== 1'b1) begin
            errors++; $display("FAIL reset_prediction: got %b required 1", prediction);
        end
        checks++;
        if (pred_valid !== 1'b0) begin
            errors++; $display("FAIL reset_pred_valid: got %b required 0", pred_valid);
        end
        checks++;
        if (branch_count !== 16'd0 || mispred_count !== 16'd0) begin
            errors++; $display("FAIL reset_stats: got %0d/%0d required 0/0", branch_count, mispred_count);
        end
        @(negedge clkFSM);
        reset = 1'b1;
        do_lookup(32'h0);
        checks++;
        if (pred_valid !== 1'b1 || prediction !== 1'b1) begin
            errors++; $display("FAIL reset_lookup: got valid=%b pred=%b required 1/1", pred_valid, prediction);
        end
        tick();
        checks++;
        if (pred_valid !== 1'b0 || prediction !== 1'b1) begin
            errors++; $display("FAIL idle_hold: got valid=%b pred=%b required 0/1", pred_valid, prediction);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 3; i++) do_update(32'h40, 1'b0, 1'b0);
        do_lookup(32'h40);
        checks++;
        if (prediction !== 1'b0) begin
            errors++; $display("FAIL sat_low: got %b required 0", prediction);
        end
        do_update(32'h40, 1'b1, 1'b1);
        do_lookup(32'h40);
        checks++;
        if (prediction !== 1'b0) begin
            errors++; $display("FAIL sat_one_taken: got %b required 0", prediction);
        end
        for (int i = 0; i < 2; i++) do_update(32'h40, 1'b1, 1'b1);
        do_lookup(32'h40);
        checks++;
        if (prediction !== 1'b1) begin
            errors++; $display("FAIL sat_three_taken: got %b required 1", prediction);
        end
        for (int i = 0; i < 5; i++) do_update(32'h40, 1'b1, 1'b1);
        // Counter must sit at 3: one not-taken keeps it taken, a second does not.
        do_update(32'h40, 1'b0, 1'b1);
        do_lookup(32'h40);
        checks++;
        if (prediction !== 1'b1) begin
            errors++; $display("FAIL sat_high_minus1: got %b required 1", prediction);
        end
        do_update(32'h40, 1'b0, 1'b1);
        do_lookup(32'h40);
        checks++;
        if (prediction !== 1'b0) begin
            errors++; $display("FAIL sat_high_minus2: got %b required 0", prediction);
        end
    endtask

    task automatic test_alias();
        do_update(32'h04, 1'b0, 1'b0);
        do_update(32'h04, 1'b0, 1'b0);
        do_lookup(32'h44);
        checks++;
        if (prediction !== 1'b0) begin
            errors++; $display("FAIL alias_44: got %b required 0", prediction);
        end
        do_lookup(32'h08);
        checks++;
        if (prediction !== 1'b1) begin
            errors++; $display("FAIL index_08: got %b required 1", prediction);
        end
        do_lookup(32'hFFFF_FF07);
        checks++;
        if (prediction !== 1'b0) begin
            errors++; $display("FAIL alias_high_low_bits: got %b required 0", prediction);
        end
    endtask

    task automatic test_read_before_write();
        do_update(32'h04, 1'b1, 1'b1);
        do_update(32'h04, 1'b1, 1'b1);
        lookup_valid  = 1'b1;
        lookup_pc     = 32'h04;
        upd_valid     = 1'b1;
        upd_pc        = 32'h04;
        upd_taken     = 1'b0;
        upd_predicted = 1'b1;
        tick();
        upd_valid = 1'b0;
        checks++;
        if (prediction !== 1'b1) begin
            errors++; $display("FAIL rbw_same_cycle: got %b required 1", prediction);
        end
        tick();
        lookup_valid = 1'b0;
        checks++;
        if (prediction !== 1'b0) begin
            errors++; $display("FAIL rbw_next_cycle: got %b required 0", prediction);
        end
    endtask

    task automatic test_back_to_back_lookup();
        logic [31:0] pcs [3];
        logic        exp [3];
        // idx1 = 1, idx2 = 2 (untouched), idx0 = 1
        pcs[0] = 32'h04; exp[0] = 1'b0;
        pcs[1] = 32'h08; exp[1] = 1'b1;
        pcs[2] = 32'h40; exp[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            lookup_valid = 1'b1;
            lookup_pc    = pcs[i];
            tick();
            checks++;
            if (pred_valid !== 1'b1 || prediction !== exp[i]) begin
                errors++; $display("FAIL b2b_lookup_%0d: got valid=%b pred=%b required 1/%b", i, pred_valid, prediction, exp[i]);
            end
        end
        lookup_valid = 1'b0;
    endtask

    task automatic test_x_pc();
        do_lookup(32'h08);
        lookup_valid = 1'b0;
        lookup_pc    = 'x;
        tick();
        tick();
        checks++;
        if (pred_valid !== 1'b0 || prediction !== 1'b1) begin
            errors++; $display("FAIL x_pc_idle: got valid=%b pred=%b required 0/1", pred_valid, prediction);
        end
        do_lookup(32'h04);
        checks++;
        if (prediction !== 1'b0) begin
            errors++; $display("FAIL x_pc_table: got %b required 0", prediction);
        end
    endtask

    task automatic test_stats();
        stat_clear = 1'b1;
        tick();
        stat_clear = 1'b0;
        checks++;
        if (branch_count !== 16'd0 || mispred_count !== 16'd0) begin
            errors++; $display("FAIL stat_clear: got %0d/%0d required 0/0", branch_count, mispred_count);
        end
        for (int i = 0; i < 10; i++) begin
            upd_valid     = 1'b1;
            upd_pc        = 32'h30;
            upd_taken     = 1'(i % 2);
            upd_predicted = (i < 3) ? ~upd_taken : upd_taken;
            tick();
        end
        upd_valid = 1'b0;
        checks++;
        if (branch_count !== 16'd10) begin
            errors++; $display("FAIL stat_branch_10: got %0d required 10", branch_count);
        end
        checks++;
        if (mispred_count !== 16'd3) begin
            errors++; $display("FAIL stat_mispred_3: got %0d required 3", mispred_count);
        end
        stat_clear    = 1'b1;
        upd_valid     = 1'b1;
        upd_pc        = 32'h30;
        upd_taken     = 1'b1;
        upd_predicted = 1'b0;
        tick();
        stat_clear = 1'b0;
        upd_valid  = 1'b0;
        checks++;
        if (branch_count !== 16'd0 || mispred_count !== 16'd0) begin
            errors++; $display("FAIL stat_clear_priority: got %0d/%0d required 0/0", branch_count, mispred_count);
        end
        do_lookup(32'h04);
        checks++;
        if (prediction !== 1'b0) begin
            errors++; $display("FAIL stat_clear_table: got %b required 0", prediction);
        end
        for (int i = 0; i < 20; i++) begin
            upd_valid     = 1'b1;
            upd_pc        = 32'h30;
            upd_taken     = 1'b1;
            upd_predicted = 1'b0;
            tick();
        end
        upd_valid = 1'b0;
        checks++;
        if (branch_count !== 16'd20 || mispred_count !== 16'd20) begin
            errors++; $display("FAIL stat_wide_20: got %0d/%0d required 20/20", branch_count, mispred_count);
        end
        checks++;
        if (branch_count_s !== 4'd15) begin
            errors++; $display("FAIL stat_sat_branch: got %0d required 15", branch_count_s);
        end
        checks++;
        if (mispred_count_s !== 4'd15) begin
            errors++; $display("FAIL stat_sat_mispred: got %0d required 15", mispred_count_s);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 4; i++) begin
            upd_valid     = 1'b1;
            upd_pc        = 32'h10;
            upd_taken     = 1'b0;
            upd_predicted = 1'b1;
            lookup_valid  = 1'b1;
            lookup_pc     = 32'h04;
            tick();
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (prediction !== 1'b1 || pred_valid !== 1'b0) begin
            errors++; $display("FAIL async_reset_pred: got pred=%b valid=%b required 1/0", prediction, pred_valid);
        end
        checks++;
        if (branch_count !== 16'd0 || mispred_count !== 16'd0) begin
            errors++; $display("FAIL async_reset_stats: got %0d/%0d required 0/0", branch_count, mispred_count);
        end
        upd_valid    = 1'b0;
        lookup_valid = 1'b0;
        tick();
        #2 reset = 1'b1;
        for (int i = 0; i < 16; i++) begin
            lookup_valid = 1'b1;
            lookup_pc    = 32'(i) << 2;
            tick();
            checks++;
            if (pred_valid !== 1'b1 || prediction !== 1'b1) begin
                errors++; $display("FAIL post_reset_idx_%0d: got valid=%b pred=%b required 1/1", i, pred_valid, prediction);
            end
        end
        lookup_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_saturation();
        test_alias();
        test_read_before_write();
        test_back_to_back_lookup();
        test_x_pc();
        test_stats();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
